// File: rtl/dht_frame_decoder.sv
// DHT sensor frame decoder: checksum validation, binary-to-BCD conversion of the
// integer humidity/temperature bytes, and saturating error/timeout event counters.
module dht_frame_decoder #(
  parameter int DHT_OUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_done,
  input  logic [DHT_OUT-1:0] i_data,
  input  logic               i_tout,
  output logic [7:0]         o_hum_int,
  output logic [7:0]         o_hum_dec,
  output logic [7:0]         o_tmp_int,
  output logic [7:0]         o_tmp_dec,
  output logic [11:0]        o_hum_bcd,
  output logic [11:0]        o_tmp_bcd,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_err,
  output logic [7:0]         o_err_cnt,
  output logic [7:0]         o_tout_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, CONV, UPDATE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DHT_OUT-1:0] r_frame;
  logic [3:0]         r_iter;
  logic [7:0]         r_hum_bin;
  logic [7:0]         r_tmp_bin;
  logic [11:0]        r_hum_conv;
  logic [11:0]        r_tmp_conv;
  logic               r_tout_d;

  logic [7:0]         r_hum_int;
  logic [7:0]         r_hum_dec;
  logic [7:0]         r_tmp_int;
  logic [7:0]         r_tmp_dec;
  logic [11:0]        r_hum_bcd;
  logic [11:0]        r_tmp_bcd;
  logic               r_valid;
  logic               r_err;
  logic [7:0]         r_err_cnt;
  logic [7:0]         r_tout_cnt;

  logic [7:0]         w_sum;
  logic               w_sum_ok;
  logic               w_tout_rise;
  logic [11:0]        w_hum_adj;
  logic [11:0]        w_tmp_adj;

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] v;
    v = b;
    for (int n = 0; n < 3; n++)
      if (v[n*4 +: 4] >= 4'd5) v[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
    return v;
  endfunction

  assign w_sum       = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
  assign w_sum_ok    = (w_sum == r_frame[7:0]);
  assign w_tout_rise = i_tout & ~r_tout_d;
  assign w_hum_adj   = add3(r_hum_conv);
  assign w_tmp_adj   = add3(r_tmp_conv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_done) w_next = CHECK;
      CHECK:   w_next = w_sum_ok ? CONV : IDLE;
      CONV:    if (r_iter == 4'd7) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame capture and the 8-step conversion; the binary bytes shift out MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame    <= '0;
      r_iter     <= '0;
      r_hum_bin  <= '0;
      r_tmp_bin  <= '0;
      r_hum_conv <= '0;
      r_tmp_conv <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_done) r_frame <= i_data;
        CHECK: begin
          r_iter     <= '0;
          r_hum_bin  <= r_frame[39:32];
          r_tmp_bin  <= r_frame[23:16];
          r_hum_conv <= '0;
          r_tmp_conv <= '0;
        end
        CONV: begin
          r_hum_conv <= (w_hum_adj << 1) | {11'd0, r_hum_bin[7]};
          r_tmp_conv <= (w_tmp_adj << 1) | {11'd0, r_tmp_bin[7]};
          r_hum_bin  <= {r_hum_bin[6:0], 1'b0};
          r_tmp_bin  <= {r_tmp_bin[6:0], 1'b0};
          r_iter     <= r_iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hum_int  <= '0;
      r_hum_dec  <= '0;
      r_tmp_int  <= '0;
      r_tmp_dec  <= '0;
      r_hum_bcd  <= '0;
      r_tmp_bcd  <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_tout_cnt <= '0;
      r_tout_d   <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_tout_d <= i_tout;
      if (r_state == UPDATE) begin
        r_hum_int <= r_frame[39:32];
        r_hum_dec <= r_frame[31:24];
        r_tmp_int <= r_frame[23:16];
        r_tmp_dec <= r_frame[15:8];
        r_hum_bcd <= r_hum_conv;
        r_tmp_bcd <= r_tmp_conv;
        r_err     <= 1'b0;
        r_valid   <= 1'b1;
      end
      if (r_state == CHECK && !w_sum_ok) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_tout_rise && r_tout_cnt != 8'hFF) r_tout_cnt <= r_tout_cnt + 8'd1;
    end
  end

  assign o_hum_int  = r_hum_int;
  assign o_hum_dec  = r_hum_dec;
  assign o_tmp_int  = r_tmp_int;
  assign o_tmp_dec  = r_tmp_dec;
  assign o_hum_bcd  = r_hum_bcd;
  assign o_tmp_bcd  = r_tmp_bcd;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state != IDLE);
  assign o_err      = r_err;
  assign o_err_cnt  = r_err_cnt;
  assign o_tout_cnt = r_tout_cnt;

endmodule

// File: tb/tb_dht_frame_decoder.sv
// Self-checking bench for dht_frame_decoder: directed spec scenarios plus random
// frames compared against an arithmetic reference model.
module tb_dht_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_done;
  logic [39:0] i_data;
  logic        i_tout;
  logic [7:0]  o_hum_int, o_hum_dec, o_tmp_int, o_tmp_dec;
  logic [11:0] o_hum_bcd, o_tmp_bcd;
  logic        o_valid, o_busy, o_err;
  logic [7:0]  o_err_cnt, o_tout_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_hum_int, m_hum_dec, m_tmp_int, m_tmp_dec;
  logic [11:0] m_hum_bcd, m_tmp_bcd;
  logic        m_err;
  int          m_err_cnt, m_tout_cnt;

  logic [55:0] obs_data;
  logic [18:0] obs_status;

  dht_frame_decoder #(.DHT_OUT(40)) dut (
    .clk(clk), .rst(rst), .i_done(i_done), .i_data(i_data), .i_tout(i_tout),
    .o_hum_int(o_hum_int), .o_hum_dec(o_hum_dec), .o_tmp_int(o_tmp_int), .o_tmp_dec(o_tmp_dec),
    .o_hum_bcd(o_hum_bcd), .o_tmp_bcd(o_tmp_bcd), .o_valid(o_valid), .o_busy(o_busy),
    .o_err(o_err), .o_err_cnt(o_err_cnt), .o_tout_cnt(o_tout_cnt)
  );

  always #5 clk = ~clk;

  assign obs_data   = {o_hum_int, o_hum_dec, o_tmp_int, o_tmp_dec, o_hum_bcd, o_tmp_bcd};
  assign obs_status = {o_valid, o_busy, o_err, o_err_cnt, o_tout_cnt};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic bit csum_ok(input logic [39:0] f);
    return ((int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] with_good_csum(input logic [39:0] f);
    logic [39:0] g;
    g = f;
    g[7:0] = 8'((int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256);
    return g;
  endfunction

  function automatic logic [55:0] exp_data();
    return {m_hum_int, m_hum_dec, m_tmp_int, m_tmp_dec, m_hum_bcd, m_tmp_bcd};
  endfunction

  task automatic model_reset();
    {m_hum_int, m_hum_dec, m_tmp_int, m_tmp_dec} = '0;
    m_hum_bcd = '0; m_tmp_bcd = '0; m_err = 1'b0;
    m_err_cnt = 0; m_tout_cnt = 0;
  endtask

  task automatic model_frame(input logic [39:0] f, output int exp_valid);
    if (csum_ok(f)) begin
      m_hum_int = f[39:32]; m_hum_dec = f[31:24];
      m_tmp_int = f[23:16]; m_tmp_dec = f[15:8];
      m_hum_bcd = to_bcd(int'(f[39:32]));
      m_tmp_bcd = to_bcd(int'(f[23:16]));
      m_err = 1'b0;
      exp_valid = 1;
    end else begin
      m_err = 1'b1;
      if (m_err_cnt < 255) m_err_cnt++;
      exp_valid = 0;
    end
  endtask

  // Pulses i_done for one cycle (cycle 0) and observes cycles 1..14; i_data is scrambled afterwards.
  task automatic send_frame(input logic [39:0] f, output int nvalid, output int first, output int nbusy);
    i_data = f;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    i_data = {8'($urandom), 32'($urandom)};
    nvalid = 0; first = -1; nbusy = 0;
    for (int c = 1; c <= 14; c++) begin
      if (o_valid) begin
        nvalid++;
        if (first < 0) first = c;
      end
      if (o_busy) nbusy++;
      if (c < 14) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_done = 1'b0; i_tout = 1'b0; i_data = '0;
    model_reset();
    step(); step();
    n_checks++;
    if (obs_data !== 56'd0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", obs_data);
    end
    n_checks++;
    if (obs_status !== 19'd0) begin
      n_fail++; $display("[TB] FAIL reset_status: got %h expected 0", obs_status);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_good_frame();
    int nv, fc, nb, ev;
    model_frame(40'h2D00170044, ev);
    send_frame(40'h2D00170044, nv, fc, nb);
    n_checks++;
    if (nv !== 1 || fc !== 11) begin
      n_fail++; $display("[TB] FAIL good_latency: got %0d pulses first at %0d, expected 1 at 11", nv, fc);
    end
    n_checks++;
    if (nb !== 10) begin
      n_fail++; $display("[TB] FAIL good_busy: got %0d busy cycles expected 10", nb);
    end
    n_checks++;
    if ({o_hum_int, o_tmp_int, o_hum_bcd, o_tmp_bcd, o_err} !== {8'h2D, 8'h17, 12'h045, 12'h023, 1'b0}) begin
      n_fail++; $display("[TB] FAIL good_fields: got %h %h %h %h err=%b expected 2d 17 045 023 err=0",
                         o_hum_int, o_tmp_int, o_hum_bcd, o_tmp_bcd, o_err);
    end
  endtask

  task automatic test_bad_checksum();
    int nv, fc, nb, ev;
    model_frame(40'h2D00170045, ev);
    send_frame(40'h2D00170045, nv, fc, nb);
    n_checks++;
    if (nv !== 0) begin
      n_fail++; $display("[TB] FAIL bad_no_valid: got %0d pulses expected 0", nv);
    end
    n_checks++;
    if (o_err !== 1'b1 || int'(o_err_cnt) !== m_err_cnt) begin
      n_fail++; $display("[TB] FAIL bad_err: got err=%b cnt=%0d expected err=1 cnt=%0d", o_err, o_err_cnt, m_err_cnt);
    end
    n_checks++;
    if (obs_data !== exp_data()) begin
      n_fail++; $display("[TB] FAIL bad_hold: got %h expected %h", obs_data, exp_data());
    end
    model_frame(40'h2D00170044, ev);
    send_frame(40'h2D00170044, nv, fc, nb);
    n_checks++;
    if (o_err !== 1'b0 || nv !== 1 || int'(o_err_cnt) !== m_err_cnt) begin
      n_fail++; $display("[TB] FAIL bad_then_good: got err=%b pulses=%0d cnt=%0d expected err=0 pulses=1 cnt=%0d",
                         o_err, nv, o_err_cnt, m_err_cnt);
    end
  endtask

  task automatic test_max_values();
    int nv, fc, nb, ev;
    model_frame(40'hFF00FF00FE, ev);
    send_frame(40'hFF00FF00FE, nv, fc, nb);
    n_checks++;
    if (nv !== 1 || o_hum_bcd !== 12'h255 || o_tmp_bcd !== 12'h255) begin
      n_fail++; $display("[TB] FAIL max_bcd: got pulses=%0d hum=%h tmp=%h expected 1 255 255", nv, o_hum_bcd, o_tmp_bcd);
    end
    model_frame(40'h0000000000, ev);
    send_frame(40'h0000000000, nv, fc, nb);
    n_checks++;
    if (nv !== 1 || obs_data !== exp_data() || o_hum_bcd !== 12'h000) begin
      n_fail++; $display("[TB] FAIL zero_frame: got pulses=%0d data=%h expected 1 %h", nv, obs_data, exp_data());
    end
  endtask

  task automatic test_busy_drop();
    int nv, fc, ev;
    model_frame(40'h2D00170044, ev);
    i_data = 40'h2D00170044;
    i_done = 1'b1;
    step();
    nv = 0; fc = -1;
    for (int c = 1; c <= 20; c++) begin
      i_done = (c == 3);
      if (c == 3) i_data = 40'h3200140046;
      if (o_valid) begin
        nv++;
        if (fc < 0) fc = c;
      end
      step();
    end
    i_done = 1'b0;
    n_checks++;
    if (nv !== 1 || fc !== 11) begin
      n_fail++; $display("[TB] FAIL busy_drop_pulses: got %0d first at %0d expected 1 at 11", nv, fc);
    end
    n_checks++;
    if (obs_data !== exp_data()) begin
      n_fail++; $display("[TB] FAIL busy_drop_data: got %h expected %h", obs_data, exp_data());
    end
  endtask

  task automatic test_tout();
    i_tout = 1'b1;
    repeat (5) step();
    i_tout = 1'b0;
    step();
    m_tout_cnt++;
    n_checks++;
    if (int'(o_tout_cnt) !== m_tout_cnt) begin
      n_fail++; $display("[TB] FAIL tout_level: got %0d expected %0d", o_tout_cnt, m_tout_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      i_tout = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      i_tout = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      m_tout_cnt++;
    end
    n_checks++;
    if (int'(o_tout_cnt) !== m_tout_cnt || o_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL tout_pulses: got cnt=%0d busy=%b expected cnt=%0d busy=0", o_tout_cnt, o_busy, m_tout_cnt);
    end
  endtask

  task automatic test_coincident();
    int ev;
    model_frame(40'h2D00170045, ev);
    m_tout_cnt++;
    i_data = 40'h2D00170045;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    i_tout = 1'b1;
    step();
    i_tout = 1'b0;
    step(); step();
    n_checks++;
    if (int'(o_err_cnt) !== m_err_cnt || int'(o_tout_cnt) !== m_tout_cnt) begin
      n_fail++; $display("[TB] FAIL coincident: got err_cnt=%0d tout_cnt=%0d expected %0d %0d",
                         o_err_cnt, o_tout_cnt, m_err_cnt, m_tout_cnt);
    end
  endtask

  task automatic test_random();
    int nv, fc, nb, ev;
    logic [39:0] f;
    for (int k = 0; k < 40; k++) begin
      f = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) f = with_good_csum(f);
      model_frame(f, ev);
      send_frame(f, nv, fc, nb);
      n_checks++;
      if (nv !== ev || (ev == 1 && fc !== 11)) begin
        n_fail++; $display("[TB] FAIL random_valid[%0d]: frame %h got %0d pulses at %0d expected %0d at 11", k, f, nv, fc, ev);
      end
      n_checks++;
      if (obs_data !== exp_data() || o_err !== m_err || int'(o_err_cnt) !== m_err_cnt) begin
        n_fail++; $display("[TB] FAIL random_out[%0d]: frame %h got %h err=%b cnt=%0d expected %h err=%b cnt=%0d",
                           k, f, obs_data, o_err, o_err_cnt, exp_data(), m_err, m_err_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    int nv, fc, nb, ev;
    i_data = 40'h1E00190037;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_data !== 56'd0 || obs_status !== 19'd0) begin
      n_fail++; $display("[TB] FAIL midconv_reset: got data=%h status=%h expected 0 0", obs_data, obs_status);
    end
    step(); step();
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      if (o_valid) nv++;
      step();
    end
    n_checks++;
    if (nv !== 0) begin
      n_fail++; $display("[TB] FAIL midconv_no_valid: got %0d pulses expected 0", nv);
    end
    model_frame(40'h2D00170044, ev);
    send_frame(40'h2D00170044, nv, fc, nb);
    n_checks++;
    if (nv !== 1 || fc !== 11 || obs_data !== exp_data() || o_err_cnt !== 8'd0) begin
      n_fail++; $display("[TB] FAIL midconv_recover: got pulses=%0d at %0d data=%h cnt=%0d expected 1 at 11 %h 0",
                         nv, fc, obs_data, o_err_cnt, exp_data());
    end
  endtask

  task automatic test_saturation();
    int ev, nv, fc, nb;
    logic [39:0] f;
    for (int k = 0; k < 300; k++) begin
      f = with_good_csum({8'($urandom), 32'($urandom)});
      f[7:0] = f[7:0] + 8'd1;
      model_frame(f, ev);
      i_data = f;
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      step(); step();
    end
    n_checks++;
    if (int'(o_err_cnt) !== m_err_cnt || o_err_cnt !== 8'd255) begin
      n_fail++; $display("[TB] FAIL err_saturate: got %0d expected 255", o_err_cnt);
    end
    n_checks++;
    if (obs_data !== exp_data() || o_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL saturate_hold: got %h err=%b expected %h err=1", obs_data, o_err, exp_data());
    end
    model_frame(40'h0A0B0C0D2E, ev);
    send_frame(40'h0A0B0C0D2E, nv, fc, nb);
    n_checks++;
    if (nv !== 1 || o_err !== 1'b0 || o_err_cnt !== 8'd255 || obs_data !== exp_data()) begin
      n_fail++; $display("[TB] FAIL saturate_then_good: got pulses=%0d err=%b cnt=%0d data=%h expected 1 0 255 %h",
                         nv, o_err, o_err_cnt, obs_data, exp_data());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_max_values();
    test_busy_drop();
    test_tout();
    test_coincident();
    test_random();
    test_reset_mid_conv();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
